fetch_pc_unit: RTL

Instruction-fetch stage of the RISC-V core. Holds the program counter, issues one instruction-memory read at a time, buffers the returned word, and presents {pc, instr} to decode over a valid/ready handshake. The sequential PC comes from a 32-bit PC+4 incrementer. Control-flow changes arrive from execute as a redirect that squashes any in-flight fetch.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_pc_adder.sv | 13 +
 rtl/fetch_pc_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: widths, PC step,
// reset NOP encoding and the fetch FSM state type.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_adder.sv
// Sequential-PC incrementer: plain modulo-2^W add, carry out discarded
// so the top of the address space wraps to zero.
module fetch_pc_adder #(
    parameter int W = riscv_pkg::XLEN
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight,
// buffers the returned word and hands {pc, instr} to decode.
module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n, ibuf, ibuf_n, pc_inc, target;
    logic            drop, drop_n;

    fetch_pc_adder #(.W(XLEN)) u_adder (
        .a   (pc),
        .b   (PC_STEP),
        .sum (pc_inc)
    );

    assign target = {redirect_pc[XLEN-1:2], 2'b00};

    // All handshake outputs come straight from registers.
    assign imem_req_valid = (state == REQ);
    assign if_valid       = (state == HOLD);
    assign imem_req_addr  = pc;
    assign if_pc          = pc;
    assign if_instr       = ibuf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
            ibuf  <= NOP_INSTR;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ibuf  <= ibuf_n;
            drop  <= drop_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ibuf_n  = ibuf;
        drop_n  = drop;
        case (state)
            BOOT: state_n = REQ;
            REQ: begin
                if (redirect_valid) pc_n = target;
                if (imem_req_ready) begin
                    state_n = WAIT;
                    drop_n  = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_n   = target;
                    drop_n = 1'b1;
                end
                // A squashed fetch still owes us its response; swallow it.
                if (imem_rsp_valid) begin
                    if (drop || redirect_valid) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        ibuf_n  = imem_rsp_data;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_n    = target;
                    state_n = REQ;
                end else if (if_ready) begin
                    pc_n    = pc_inc;
                    state_n = REQ;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    a_rsp_in_wait: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> state == WAIT)
        else $error("imem response outside WAIT");

endmodule
